// File: rtl/tsense_pulse_array.sv
// Multi-channel LMT01 pulse-train counter: windowed edge counting with
// dead-time filtering, converted to signed 1/16 degC per channel.
module tsense_pulse_array #(
    parameter int CH       = 4,
    parameter int WIN_CYC  = 12800000,
    parameter int DEAD_CYC = 1450,
    parameter int CNT_W    = 12,
    parameter int OUT_W    = 12
) (
    input  logic                clk,
    input  logic                reset_count,
    input  logic [CH-1:0]       pulse_i,
    input  logic [CH-1:0]       ch_en,
    input  logic                single_shot,
    input  logic                start,
    output logic [CH*OUT_W-1:0] temp_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic [CH-1:0]       fault_o,
    output logic [CH-1:0]       ovf_o
);

    localparam int WW  = $clog2(WIN_CYC);
    localparam int DTW = $clog2(DEAD_CYC + 1);
    localparam int DW  = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 2;

    localparam logic [WW-1:0]         WLAST = WW'(WIN_CYC - 1);
    localparam logic [DTW-1:0]        DLOAD = DTW'(DEAD_CYC);
    localparam logic signed [DW-1:0]  OFS   = DW'(800);
    localparam logic signed [DW-1:0]  TMAX  = DW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [DW-1:0]  TMIN  = ~TMAX;

    typedef enum logic {IDLE, WINDOW} state_t;

    state_t        state;
    state_t        state_nx;
    logic [WW-1:0] win_cnt;
    logic          win_end;
    logic [CH-1:0] sync1;
    logic [CH-1:0] sync2;
    logic [CH-1:0] sync3;
    logic [CH-1:0] rise;

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= pulse_i;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise    = sync2 & ~sync3;
    assign win_end = (state == WINDOW) && (win_cnt == WLAST);

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // single_shot only matters here: in IDLE and on the last window cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!single_shot || start) begin
                    state_nx = WINDOW;
                end
            end
            WINDOW: begin
                if (win_end && single_shot) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == WINDOW);
    end

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            win_cnt <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= win_end;
            if (state == WINDOW && !win_end) begin
                win_cnt <= win_cnt + 1'b1;
            end else begin
                win_cnt <= '0;
            end
        end
    end

    for (genvar n = 0; n < CH; n++) begin : g_ch
        logic [CNT_W-1:0]       cnt;
        logic [CNT_W-1:0]       cnt_nx;
        logic [DTW-1:0]         dead;
        logic                   acc;
        logic                   sat;
        logic                   ovf_f;
        logic                   ovf_nx;
        logic signed [DW-1:0]   diff;
        logic [OUT_W-1:0]       temp_nx;
        logic [OUT_W-1:0]       temp_r;
        logic                   fault_r;
        logic                   ovf_r;

        assign acc    = ch_en[n] & busy_o & rise[n] & (dead == '0);
        assign sat    = &cnt;
        assign cnt_nx = (acc && !sat) ? cnt + 1'b1 : cnt;
        assign ovf_nx = ovf_f | (acc & sat);
        assign diff   = $signed({{(DW-CNT_W){1'b0}}, cnt_nx}) - OFS;

        always_comb begin
            temp_nx = diff[OUT_W-1:0];
            if (diff > TMAX) begin
                temp_nx = TMAX[OUT_W-1:0];
            end else if (diff < TMIN) begin
                temp_nx = TMIN[OUT_W-1:0];
            end
        end

        // counts the ending window's last edge, then clears for the next one
        always_ff @(posedge clk or posedge reset_count) begin
            if (reset_count) begin
                cnt   <= '0;
                dead  <= '0;
                ovf_f <= 1'b0;
            end else if (win_end || !ch_en[n]) begin
                cnt   <= '0;
                dead  <= '0;
                ovf_f <= 1'b0;
            end else begin
                cnt   <= cnt_nx;
                ovf_f <= ovf_nx;
                if (acc) begin
                    dead <= DLOAD;
                end else if (dead != '0) begin
                    dead <= dead - 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset_count) begin
            if (reset_count) begin
                temp_r  <= '0;
                fault_r <= 1'b0;
                ovf_r   <= 1'b0;
            end else if (win_end) begin
                temp_r  <= ch_en[n] ? temp_nx : '0;
                fault_r <= ch_en[n] & (cnt_nx == '0);
                ovf_r   <= ch_en[n] & ovf_nx;
            end
        end

        assign temp_o[n*OUT_W +: OUT_W] = temp_r;
        assign fault_o[n]               = fault_r;
        assign ovf_o[n]                 = ovf_r;
    end

endmodule

// File: tb/tb_tsense_pulse_array.sv
// Random and directed pulse windows against an edge-list temperature model,
// checked by a scoreboard that pops on every valid_o strobe.
module tb_tsense_pulse_array;

    localparam int WIN  = 20000;
    localparam int DEAD = 3;

    typedef struct {
        int          cyc;
        logic [47:0] t;
        logic [3:0]  f;
        logic [3:0]  o;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_count;
    logic [3:0]  pulse_i;
    logic [3:0]  ch_en;
    logic        single_shot;
    logic        start;
    logic [47:0] temp_o;
    logic        valid_o;
    logic        busy_o;
    logic [3:0]  fault_o;
    logic [3:0]  ovf_o;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nvalid = 0;
    exp_t sb[$];
    int   eq[4][$];
    logic [3:0] evmap [0:WIN+1];

    tsense_pulse_array #(
        .CH(4), .WIN_CYC(WIN), .DEAD_CYC(DEAD), .CNT_W(12), .OUT_W(12)
    ) dut (
        .clk(clk),
        .reset_count(reset_count),
        .pulse_i(pulse_i),
        .ch_en(ch_en),
        .single_shot(single_shot),
        .start(start),
        .temp_o(temp_o),
        .valid_o(valid_o),
        .busy_o(busy_o),
        .fault_o(fault_o),
        .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // temperature from the list of edge times: an edge counts only if more
    // than DEAD cycles passed since the previous counted edge
    function automatic void model(input logic [3:0] en, output logic [47:0] t,
                                  output logic [3:0] f, output logic [3:0] o);
        t = '0;
        f = '0;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            int cnt;
            int last;
            int tv;
            bit ov;
            cnt = 0;
            last = -1000;
            ov = 0;
            for (int i = 0; i < eq[c].size(); i++) begin
                if (eq[c][i] - last > DEAD) begin
                    last = eq[c][i];
                    if (cnt == 4095) ov = 1;
                    else cnt++;
                end
            end
            tv = cnt - 800;
            if (tv > 2047) tv = 2047;
            if (tv < -2048) tv = -2048;
            if (en[c]) begin
                t[c*12 +: 12] = 12'(tv);
                f[c] = (cnt == 0);
                o[c] = ov;
            end
        end
    endfunction

    task automatic gen_plan(input int c, input int gmin, input int gmax,
                            input int limit);
        int t;
        eq[c].delete();
        t = 2 + int'($urandom_range(5, 0));
        while (t < limit) begin
            eq[c].push_back(t);
            t += int'($urandom_range(gmax, gmin));
        end
    endtask

    // entered at the negedge of window cycle 0; returns nk negedges later
    task automatic run_window(input int nk, input bit push_exp);
        exp_t e;
        for (int k = 0; k < WIN + 2; k++) evmap[k] = '0;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < eq[c].size(); i++)
                evmap[eq[c][i]][c] = 1'b1;
        if (push_exp) begin
            e.cyc = cyc + WIN;
            model(ch_en, e.t, e.f, e.o);
            sb.push_back(e);
        end
        for (int k = 0; k < nk; k++) begin
            pulse_i = evmap[k+2];
            start = (k == 500);
            if (k == 0 || k == WIN - 1) chk("busy_in_window", busy_o, 1);
            @(negedge clk);
        end
        pulse_i = '0;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset_count && valid_o) begin
            exp_t e;
            nvalid++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got 1 want 0 at cyc %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("valid_latency", 64'(cyc), 64'(e.cyc));
                chk("temp", 64'(temp_o), 64'(e.t));
                chk("fault", 64'(fault_o), 64'(e.f));
                chk("ovf", 64'(ovf_o), 64'(e.o));
            end
        end
    end

    initial begin
        int busy_hi;
        reset_count = 1'b1;
        single_shot = 1'b0;
        start = 1'b0;
        ch_en = 4'hF;
        pulse_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_temp", 64'(temp_o), 0);
        chk("rst_valid", 64'(valid_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_flags", 64'({fault_o, ovf_o}), 0);
        reset_count = 1'b0;
        @(negedge clk);

        // directed: 1600 pulses, idle channel, dead-time pair, saturation
        for (int c = 0; c < 4; c++) eq[c].delete();
        for (int i = 0; i < 1600; i++) eq[0].push_back(10 + 4 * i);
        eq[2].push_back(100);
        eq[2].push_back(102);
        eq[2].push_back(104);
        for (int i = 0; i < 4100; i++) eq[3].push_back(20 + 4 * i);
        run_window(WIN, 1);

        // random densities, ch0 also has an edge on the last window cycle
        gen_plan(0, 2, 7, 19990);
        eq[0].push_back(WIN - 1);
        gen_plan(1, 3, 9, 19990);
        gen_plan(2, 2, 4, 19990);
        gen_plan(3, 2, 3, 19990);
        run_window(WIN, 1);

        // partial window cut by reset
        for (int c = 0; c < 4; c++) gen_plan(c, 2, 6, 19990);
        run_window(10000, 0);
        reset_count = 1'b1;
        #1;
        chk("mid_rst_temp", 64'(temp_o), 0);
        chk("mid_rst_flags", 64'({fault_o, ovf_o}), 0);
        chk("mid_rst_valid", 64'(valid_o), 0);
        chk("mid_rst_busy", 64'(busy_o), 0);
        single_shot = 1'b1;
        ch_en = 4'($urandom_range(14, 1));
        repeat (3) @(negedge clk);
        reset_count = 1'b0;
        repeat (5) @(negedge clk);
        chk("ss_idle_busy", 64'(busy_o), 0);

        // single shot, start re-pulsed at window cycle 500
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) gen_plan(c, 2, 6, 19990);
        run_window(WIN, 1);
        chk("ss_end_busy", 64'(busy_o), 0);
        busy_hi = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy_o) busy_hi++;
        end
        chk("ss_stays_idle", 64'(busy_hi), 0);
        chk("sb_empty", 64'(sb.size()), 0);
        chk("valid_count", 64'(nvalid), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
